// File: rtl/mig_rw_arbiter_if.sv
// mig_rw_arbiter_if: source, controller and status signals of the
// write/read owner arbiter in front of the MIG user port.
interface mig_rw_arbiter_if #(
    parameter int ADDR_W = 28,
    parameter int LEN_W  = 16
);

    logic              init_calib_complete;

    logic              wr_src_req;
    logic [ADDR_W-1:0] wr_src_addr;
    logic [LEN_W-1:0]  wr_src_len;
    logic              rd_src_req;
    logic [ADDR_W-1:0] rd_src_addr;
    logic [LEN_W-1:0]  rd_src_len;

    logic              wr_grant;
    logic              rd_grant;

    logic              wr_req;
    logic [ADDR_W-1:0] wr_req_addr;
    logic [LEN_W-1:0]  wr_length;
    logic              wr_done;

    logic              rd_req;
    logic [ADDR_W-1:0] rd_req_addr;
    logic [LEN_W-1:0]  rd_length;
    logic              rd_done;

    logic              arb_busy;
    logic [1:0]        arb_state;
    logic              timeout_err;

    modport master (
        input  init_calib_complete,
        input  wr_src_req,
        input  wr_src_addr,
        input  wr_src_len,
        input  rd_src_req,
        input  rd_src_addr,
        input  rd_src_len,
        output wr_grant,
        output rd_grant,
        output wr_req,
        output wr_req_addr,
        output wr_length,
        input  wr_done,
        output rd_req,
        output rd_req_addr,
        output rd_length,
        input  rd_done,
        output arb_busy,
        output arb_state,
        output timeout_err
    );

    modport slave (
        output init_calib_complete,
        output wr_src_req,
        output wr_src_addr,
        output wr_src_len,
        output rd_src_req,
        output rd_src_addr,
        output rd_src_len,
        input  wr_grant,
        input  rd_grant,
        input  wr_req,
        input  wr_req_addr,
        input  wr_length,
        output wr_done,
        input  rd_req,
        input  rd_req_addr,
        input  rd_length,
        output rd_done,
        input  arb_busy,
        input  arb_state,
        input  timeout_err
    );

endinterface

// File: rtl/mig_rw_arbiter.sv
// mig_rw_arbiter: round-robin ownership of one MIG user port between a
// write and a read burst source, with a grant-to-done watchdog.
module mig_rw_arbiter #(
    parameter int ADDR_W  = 28,
    parameter int LEN_W   = 16,
    parameter int TIMEOUT = 65535
) (
    input  logic             ui_clk,
    input  logic             rst_n,
    mig_rw_arbiter_if.master bus
);

    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam int MAX_W = (TO_W > LEN_W) ? TO_W : LEN_W;
    localparam int CNT_W = (MAX_W > 32) ? 32 : MAX_W;

    // Last watchdog value at which the owner may still finish normally.
    localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic              last_rd_q;
    logic              last_rd_d;
    logic [CNT_W-1:0]  wdog_q;
    logic [CNT_W-1:0]  wdog_d;
    logic              terr_q;
    logic              terr_d;

    logic              wr_pulse_q;
    logic              wr_pulse_d;
    logic              rd_pulse_q;
    logic              rd_pulse_d;

    logic [ADDR_W-1:0] wr_addr_q;
    logic [ADDR_W-1:0] wr_addr_d;
    logic [LEN_W-1:0]  wr_len_q;
    logic [LEN_W-1:0]  wr_len_d;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [ADDR_W-1:0] rd_addr_d;
    logic [LEN_W-1:0]  rd_len_q;
    logic [LEN_W-1:0]  rd_len_d;

    logic              wr_pend;
    logic              rd_pend;
    logic              can_grant;
    logic              pick_wr;
    logic              owner_done;
    logic              wdog_hit;

    // Pending/priority decode; a zero-length burst is never a request.
    always_comb begin
        wr_pend    = bus.wr_src_req && (bus.wr_src_len != '0);
        rd_pend    = bus.rd_src_req && (bus.rd_src_len != '0);
        can_grant  = bus.init_calib_complete && (wr_pend || rd_pend);
        pick_wr    = wr_pend && (!rd_pend || last_rd_q);
        owner_done = (state_q == ST_WR) ? bus.wr_done : bus.rd_done;
        wdog_hit   = (wdog_q == WDOG_LAST);
    end

    // Next-state and registered-output logic for the owner FSM.
    always_comb begin
        state_d    = state_q;
        last_rd_d  = last_rd_q;
        wdog_d     = wdog_q;
        terr_d     = terr_q;
        wr_pulse_d = 1'b0;
        rd_pulse_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_len_d   = wr_len_q;
        rd_addr_d  = rd_addr_q;
        rd_len_d   = rd_len_q;

        unique case (state_q)
            ST_IDLE: begin
                if (can_grant) begin
                    wdog_d = '0;
                    if (pick_wr) begin
                        state_d    = ST_WR;
                        wr_pulse_d = 1'b1;
                        wr_addr_d  = bus.wr_src_addr;
                        wr_len_d   = bus.wr_src_len;
                    end else begin
                        state_d    = ST_RD;
                        rd_pulse_d = 1'b1;
                        rd_addr_d  = bus.rd_src_addr;
                        rd_len_d   = bus.rd_src_len;
                    end
                end
            end
            ST_WR, ST_RD: begin
                wdog_d = wdog_q + CNT_W'(1);
                // A done coincident with the watchdog limit still counts
                // as a clean finish.
                if (owner_done || wdog_hit) begin
                    state_d   = ST_IDLE;
                    last_rd_d = (state_q == ST_RD);
                    if (!owner_done) begin
                        terr_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge ui_clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            last_rd_q  <= 1'b1;
            wdog_q     <= '0;
            terr_q     <= 1'b0;
            wr_pulse_q <= 1'b0;
            rd_pulse_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_len_q   <= '0;
            rd_addr_q  <= '0;
            rd_len_q   <= '0;
        end else begin
            state_q    <= state_d;
            last_rd_q  <= last_rd_d;
            wdog_q     <= wdog_d;
            terr_q     <= terr_d;
            wr_pulse_q <= wr_pulse_d;
            rd_pulse_q <= rd_pulse_d;
            wr_addr_q  <= wr_addr_d;
            wr_len_q   <= wr_len_d;
            rd_addr_q  <= rd_addr_d;
            rd_len_q   <= rd_len_d;
        end
    end

    assign bus.wr_grant    = wr_pulse_q;
    assign bus.wr_req      = wr_pulse_q;
    assign bus.rd_grant    = rd_pulse_q;
    assign bus.rd_req      = rd_pulse_q;
    assign bus.wr_req_addr = wr_addr_q;
    assign bus.wr_length   = wr_len_q;
    assign bus.rd_req_addr = rd_addr_q;
    assign bus.rd_length   = rd_len_q;
    assign bus.arb_busy    = (state_q != ST_IDLE);
    assign bus.arb_state   = state_q;
    assign bus.timeout_err = terr_q;

endmodule

// File: tb/tb_mig_rw_arbiter.sv
// tb_mig_rw_arbiter: directed scenarios plus a randomized run checked
// against a transaction-level model of the arbiter.
module tb_mig_rw_arbiter;

    timeunit 1ns;
    timeprecision 1ps;

    localparam int AW = 28;
    localparam int LW = 16;
    localparam int TO = 100;

    // status = {wr_grant, wr_req, rd_grant, rd_req, busy, state[1:0], terr}
    localparam logic [7:0] S_IDLE = 8'b0000_0000;
    localparam logic [7:0] S_WGNT = 8'b1100_1010;
    localparam logic [7:0] S_WOWN = 8'b0000_1010;
    localparam logic [7:0] S_RGNT = 8'b0011_1100;
    localparam logic [7:0] S_ROWN = 8'b0000_1100;

    logic ui_clk = 1'b0;
    logic rst_n  = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    mig_rw_arbiter_if #(.ADDR_W(AW), .LEN_W(LW)) bus ();

    mig_rw_arbiter #(
        .ADDR_W  (AW),
        .LEN_W   (LW),
        .TIMEOUT (TO)
    ) dut (
        .ui_clk (ui_clk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    always #5 ui_clk = ~ui_clk;

    function automatic logic [7:0] stat();
        return {bus.wr_grant, bus.wr_req, bus.rd_grant, bus.rd_req,
                bus.arb_busy, bus.arb_state, bus.timeout_err};
    endfunction

    task automatic tick();
        @(posedge ui_clk);
        #1;
    endtask

    task automatic clr_inputs();
        bus.init_calib_complete = 1'b0;
        bus.wr_src_req  = 1'b0;
        bus.wr_src_addr = '0;
        bus.wr_src_len  = '0;
        bus.rd_src_req  = 1'b0;
        bus.rd_src_addr = '0;
        bus.rd_src_len  = '0;
        bus.wr_done     = 1'b0;
        bus.rd_done     = 1'b0;
    endtask

    task automatic do_reset();
        clr_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        clr_inputs();
        bus.init_calib_complete = 1'b1;
        bus.wr_src_req = 1'b1;
        bus.wr_src_len = 16'd5;
        rst_n = 1'b0;
        tick();
        tick();
        vectors++;
        if (stat() !== S_IDLE) begin
            miscompares++;
            $display("FAIL reset_status: got %b want %b", stat(), S_IDLE);
        end
        vectors++;
        if ({bus.wr_req_addr, bus.wr_length,
             bus.rd_req_addr, bus.rd_length} !== '0) begin
            miscompares++;
            $display("FAIL reset_latches: got %h/%h/%h/%h want 0",
                     bus.wr_req_addr, bus.wr_length,
                     bus.rd_req_addr, bus.rd_length);
        end
        clr_inputs();
        rst_n = 1'b1;
    endtask

    task automatic test_calib_gate();
        do_reset();
        bus.wr_src_req  = 1'b1;
        bus.wr_src_len  = 16'd64;
        bus.wr_src_addr = 28'h40;
        for (int i = 0; i < 20; i++) begin
            tick();
            vectors++;
            if (stat() !== S_IDLE) begin
                miscompares++;
                $display("FAIL calib_block cyc %0d: got %b want %b",
                         i, stat(), S_IDLE);
            end
        end
        bus.init_calib_complete = 1'b1;
        tick();
        vectors++;
        if (stat() !== S_WGNT) begin
            miscompares++;
            $display("FAIL calib_grant: got %b want %b", stat(), S_WGNT);
        end
        vectors++;
        if (bus.wr_length !== 16'd64 || bus.wr_req_addr !== 28'h40) begin
            miscompares++;
            $display("FAIL calib_latch: got %h/%0d want 40/64",
                     bus.wr_req_addr, bus.wr_length);
        end
        bus.init_calib_complete = 1'b0;
        tick();
        vectors++;
        if (stat() !== S_WOWN) begin
            miscompares++;
            $display("FAIL calib_drop_keeps: got %b want %b",
                     stat(), S_WOWN);
        end
        bus.wr_done = 1'b1;
        tick();
        bus.wr_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if (stat() !== S_IDLE) begin
                miscompares++;
                $display("FAIL calib_low_block: got %b want %b",
                         stat(), S_IDLE);
            end
        end
        bus.wr_src_req = 1'b0;
    endtask

    task automatic test_contention();
        do_reset();
        bus.init_calib_complete = 1'b1;
        bus.wr_src_req  = 1'b1;
        bus.wr_src_addr = 28'h100;
        bus.wr_src_len  = 16'd4;
        bus.rd_src_req  = 1'b1;
        bus.rd_src_addr = 28'h200;
        bus.rd_src_len  = 16'd8;
        tick();
        vectors++;
        if (stat() !== S_WGNT || bus.wr_req_addr !== 28'h100) begin
            miscompares++;
            $display("FAIL cont_first: got %b/%h want %b/100",
                     stat(), bus.wr_req_addr, S_WGNT);
        end
        bus.wr_src_req  = 1'b0;
        bus.wr_src_addr = 28'h999;
        bus.wr_src_len  = 16'd7;
        bus.rd_done = 1'b1;
        tick();
        bus.rd_done = 1'b0;
        vectors++;
        if (stat() !== S_WOWN || bus.wr_req_addr !== 28'h100
            || bus.wr_length !== 16'd4) begin
            miscompares++;
            $display("FAIL cont_hold: got %b/%h/%0d want %b/100/4",
                     stat(), bus.wr_req_addr, bus.wr_length, S_WOWN);
        end
        bus.wr_done = 1'b1;
        tick();
        bus.wr_done = 1'b0;
        vectors++;
        if (stat() !== S_IDLE) begin
            miscompares++;
            $display("FAIL cont_gap: got %b want %b", stat(), S_IDLE);
        end
        tick();
        vectors++;
        if (stat() !== S_RGNT || bus.rd_req_addr !== 28'h200
            || bus.rd_length !== 16'd8 || bus.wr_req_addr !== 28'h100) begin
            miscompares++;
            $display("FAIL cont_read: got %b/%h/%0d/%h want %b/200/8/100",
                     stat(), bus.rd_req_addr, bus.rd_length,
                     bus.wr_req_addr, S_RGNT);
        end
        bus.rd_src_req = 1'b0;
        bus.rd_done = 1'b1;
        tick();
        bus.rd_done = 1'b0;
        bus.wr_done = 1'b1;
        tick();
        bus.wr_done = 1'b0;
        vectors++;
        if (stat() !== S_IDLE) begin
            miscompares++;
            $display("FAIL cont_idle_done: got %b want %b",
                     stat(), S_IDLE);
        end
    endtask

    task automatic test_round_robin();
        int got;
        int want;
        do_reset();
        bus.init_calib_complete = 1'b1;
        bus.wr_src_req  = 1'b1;
        bus.wr_src_addr = 28'h1000;
        bus.wr_src_len  = 16'd3;
        bus.rd_src_req  = 1'b1;
        bus.rd_src_addr = 28'h2000;
        bus.rd_src_len  = 16'd5;
        for (int k = 0; k < 4; k++) begin
            got = 0;
            for (int t = 0; t < 10 && got == 0; t++) begin
                tick();
                vectors++;
                if (bus.wr_grant && bus.rd_grant) begin
                    miscompares++;
                    $display("FAIL rr_double: got both grants want one");
                end
                if (bus.wr_grant) got = 1;
                else if (bus.rd_grant) got = 2;
            end
            want = (k % 2 == 0) ? 1 : 2;
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL rr_order txn %0d: got side %0d want %0d",
                         k, got, want);
            end
            tick();
            if (got == 1) bus.wr_done = 1'b1;
            if (got == 2) bus.rd_done = 1'b1;
            tick();
            bus.wr_done = 1'b0;
            bus.rd_done = 1'b0;
        end
        bus.wr_src_req = 1'b0;
        bus.rd_src_req = 1'b0;
    endtask

    task automatic test_timeout();
        do_reset();
        bus.init_calib_complete = 1'b1;
        bus.wr_src_req = 1'b1;
        bus.wr_src_len = 16'd16;
        tick();
        bus.wr_src_req = 1'b0;
        vectors++;
        if (stat() !== S_WGNT) begin
            miscompares++;
            $display("FAIL to_grant1: got %b want %b", stat(), S_WGNT);
        end
        for (int i = 1; i < TO; i++) begin
            tick();
            vectors++;
            if (stat() !== S_WOWN) begin
                miscompares++;
                $display("FAIL to_hold1 cyc %0d: got %b want %b",
                         i, stat(), S_WOWN);
            end
        end
        bus.wr_done = 1'b1;
        tick();
        bus.wr_done = 1'b0;
        vectors++;
        if (stat() !== S_IDLE) begin
            miscompares++;
            $display("FAIL to_done_race: got %b want %b", stat(), S_IDLE);
        end
        bus.wr_src_req = 1'b1;
        tick();
        bus.wr_src_req = 1'b0;
        vectors++;
        if (stat() !== S_WGNT) begin
            miscompares++;
            $display("FAIL to_grant2: got %b want %b", stat(), S_WGNT);
        end
        for (int i = 1; i < TO; i++) begin
            tick();
            vectors++;
            if (stat() !== S_WOWN) begin
                miscompares++;
                $display("FAIL to_hold2 cyc %0d: got %b want %b",
                         i, stat(), S_WOWN);
            end
        end
        tick();
        vectors++;
        if (stat() !== (S_IDLE | 8'd1)) begin
            miscompares++;
            $display("FAIL to_abort: got %b want %b", stat(), S_IDLE | 8'd1);
        end
        bus.rd_src_req = 1'b1;
        bus.rd_src_len = 16'd4;
        tick();
        bus.rd_src_req = 1'b0;
        vectors++;
        if (stat() !== (S_RGNT | 8'd1)) begin
            miscompares++;
            $display("FAIL to_after_rd: got %b want %b",
                     stat(), S_RGNT | 8'd1);
        end
        bus.rd_done = 1'b1;
        tick();
        bus.rd_done = 1'b0;
        tick();
        vectors++;
        if (stat() !== (S_IDLE | 8'd1)) begin
            miscompares++;
            $display("FAIL to_sticky: got %b want %b",
                     stat(), S_IDLE | 8'd1);
        end
    endtask

    task automatic test_zero_len();
        do_reset();
        bus.init_calib_complete = 1'b1;
        bus.wr_src_req  = 1'b1;
        bus.wr_src_len  = 16'd0;
        bus.wr_src_addr = 28'h300;
        bus.rd_src_req  = 1'b1;
        bus.rd_src_len  = 16'd8;
        bus.rd_src_addr = 28'h400;
        tick();
        vectors++;
        if (stat() !== S_RGNT) begin
            miscompares++;
            $display("FAIL zl_first: got %b want %b", stat(), S_RGNT);
        end
        tick();
        bus.rd_done = 1'b1;
        tick();
        bus.rd_done = 1'b0;
        tick();
        vectors++;
        if (stat() !== S_RGNT) begin
            miscompares++;
            $display("FAIL zl_again: got %b want %b", stat(), S_RGNT);
        end
        bus.rd_src_req = 1'b0;
        bus.rd_done = 1'b1;
        tick();
        bus.rd_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            vectors++;
            if (stat() !== S_IDLE) begin
                miscompares++;
                $display("FAIL zl_never cyc %0d: got %b want %b",
                         i, stat(), S_IDLE);
            end
        end
        bus.wr_src_req = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.init_calib_complete = 1'b1;
        bus.rd_src_req  = 1'b1;
        bus.rd_src_len  = 16'd8;
        bus.rd_src_addr = 28'h500;
        tick();
        bus.rd_src_req = 1'b0;
        tick();
        vectors++;
        if (stat() !== S_ROWN) begin
            miscompares++;
            $display("FAIL rm_own: got %b want %b", stat(), S_ROWN);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        vectors++;
        if (stat() !== S_IDLE || bus.rd_req_addr !== '0
            || bus.rd_length !== '0) begin
            miscompares++;
            $display("FAIL rm_reset: got %b/%h/%0d want %b/0/0",
                     stat(), bus.rd_req_addr, bus.rd_length, S_IDLE);
        end
        bus.rd_done = 1'b1;
        tick();
        bus.rd_done = 1'b0;
        tick();
        vectors++;
        if (stat() !== S_IDLE) begin
            miscompares++;
            $display("FAIL rm_late_done: got %b want %b", stat(), S_IDLE);
        end
    endtask

    task automatic test_random();
        int owner;
        int age;
        int pdone;
        bit last_rd;
        bit terr;
        bit wg;
        bit rg;
        bit wp;
        bit rp;
        bit d;
        logic [AW-1:0] wa;
        logic [AW-1:0] ra;
        logic [LW-1:0] wl;
        logic [LW-1:0] rl;
        logic [7:0] exp_st;
        do_reset();
        owner = 0;
        age = 0;
        last_rd = 1'b1;
        terr = 1'b0;
        wg = 1'b0;
        rg = 1'b0;
        wa = '0;
        ra = '0;
        wl = '0;
        rl = '0;
        for (int c = 0; c < 3000; c++) begin
            exp_st = {wg, wg, rg, rg, owner != 0, 2'(owner), terr};
            vectors++;
            if (stat() !== exp_st || bus.wr_req_addr !== wa
                || bus.wr_length !== wl || bus.rd_req_addr !== ra
                || bus.rd_length !== rl) begin
                miscompares++;
                $display("FAIL rand cyc %0d: got %b %h/%0d %h/%0d want %b %h/%0d %h/%0d",
                         c, stat(), bus.wr_req_addr, bus.wr_length,
                         bus.rd_req_addr, bus.rd_length,
                         exp_st, wa, wl, ra, rl);
            end
            pdone = (c < 1500) ? 5 : 200;
            rst_n = ($urandom_range(0, 499) != 0);
            bus.init_calib_complete = ($urandom_range(0, 9) != 0);
            bus.wr_src_req  = 1'($urandom_range(0, 1));
            bus.wr_src_addr = AW'($urandom);
            bus.wr_src_len  = ($urandom_range(0, 3) == 0) ? '0
                              : LW'($urandom_range(1, 300));
            bus.rd_src_req  = 1'($urandom_range(0, 1));
            bus.rd_src_addr = AW'($urandom);
            bus.rd_src_len  = ($urandom_range(0, 3) == 0) ? '0
                              : LW'($urandom_range(1, 300));
            bus.wr_done = ($urandom_range(0, pdone) == 0);
            bus.rd_done = ($urandom_range(0, pdone) == 0);
            wg = 1'b0;
            rg = 1'b0;
            if (!rst_n) begin
                owner = 0;
                age = 0;
                last_rd = 1'b1;
                terr = 1'b0;
                wa = '0;
                ra = '0;
                wl = '0;
                rl = '0;
            end else if (owner == 0) begin
                wp = bus.wr_src_req && bus.wr_src_len != 0;
                rp = bus.rd_src_req && bus.rd_src_len != 0;
                if (bus.init_calib_complete && (wp || rp)) begin
                    age = 1;
                    if (wp && (!rp || last_rd)) begin
                        owner = 1;
                        wg = 1'b1;
                        wa = bus.wr_src_addr;
                        wl = bus.wr_src_len;
                    end else begin
                        owner = 2;
                        rg = 1'b1;
                        ra = bus.rd_src_addr;
                        rl = bus.rd_src_len;
                    end
                end
            end else begin
                d = (owner == 1) ? bus.wr_done : bus.rd_done;
                if (d || age == TO) begin
                    last_rd = (owner == 2);
                    if (!d) terr = 1'b1;
                    owner = 0;
                end else begin
                    age++;
                end
            end
            tick();
        end
        rst_n = 1'b1;
        clr_inputs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL sim_timeout: run did not finish within time limit");
        $fatal(1, "simulation time limit");
    end

    initial begin
        clr_inputs();
        test_reset();
        test_calib_gate();
        test_contention();
        test_round_robin();
        test_timeout();
        test_zero_len();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
